// File: rtl/execute_stage.sv
// Execute stage of the RV32I pipeline: forwarding muxes, ALU, branch/jump resolution, E->M register.
// Latency: pcsrcE/pctargetE are combinational; all *M outputs are registered one cycle after E.
// Backpressure: none; the stage advances every cycle and bubbles arrive as zeroed controls.
//
// Ports:
//   clk, rst                 - rising-edge clock, asynchronous active-high reset
//   *E control/data inputs   - decoded instruction fields and operands from the D->E register
//   forwardAE/BE, resultW    - hazard-unit forward selects and the writeback value
//   pcsrcE, pctargetE        - fetch redirect request and target (same cycle)
//   regwriteM ... pcincr4M   - E->M pipeline register feeding the Memory stage
module execute_stage #(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            regwriteE,
    input  logic            resultsrcE,
    input  logic            memwriteE,
    input  logic            jumpE,
    input  logic            jalrE,
    input  logic            branchE,
    input  logic [2:0]      funct3E,
    input  logic [3:0]      alucontrolE,
    input  logic            alusrcE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] immextE,
    input  logic [XLEN-1:0] pcE,
    input  logic [XLEN-1:0] pcincr4E,
    input  logic [RW-1:0]   RDE,
    input  logic [1:0]      forwardAE,
    input  logic [1:0]      forwardBE,
    input  logic [XLEN-1:0] resultW,
    output logic            pcsrcE,
    output logic [XLEN-1:0] pctargetE,
    output logic            regwriteM,
    output logic            resultsrcM,
    output logic            memwriteM,
    output logic [XLEN-1:0] aluresultM,
    output logic [XLEN-1:0] writedataM,
    output logic [RW-1:0]   RDM,
    output logic [XLEN-1:0] pcincr4M
);

    // E->M register state
    logic            regwrite_q,   regwrite_d;
    logic            resultsrc_q,  resultsrc_d;
    logic            memwrite_q,   memwrite_d;
    logic [XLEN-1:0] aluresult_q,  aluresult_d;
    logic [XLEN-1:0] writedata_q,  writedata_d;
    logic [RW-1:0]   rd_q,         rd_d;
    logic [XLEN-1:0] pcincr4_q,    pcincr4_d;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic [4:0]      shamt;
    logic            cond;
    logic            taken;
    logic [XLEN-1:0] target_base;
    logic [XLEN-1:0] target_sum;

    // Forwarding: select 10 reads back our own registered ALU result (EX->EX bypass).
    always_comb begin
        unique case (forwardAE)
            2'b01:   src_a = resultW;
            2'b10:   src_a = aluresult_q;
            default: src_a = RD1E;
        endcase
        unique case (forwardBE)
            2'b01:   fwd_b = resultW;
            2'b10:   fwd_b = aluresult_q;
            default: fwd_b = RD2E;
        endcase
    end

    assign src_b = alusrcE ? immextE : fwd_b;
    assign shamt = src_b[4:0];

    always_comb begin
        alu_result = '0;
        case (alucontrolE)
            4'b0000: alu_result = src_a + src_b;
            4'b0001: alu_result = src_a - src_b;
            4'b0010: alu_result = src_a & src_b;
            4'b0011: alu_result = src_a | src_b;
            4'b0100: alu_result = src_a ^ src_b;
            4'b0101: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b0110: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            4'b0111: alu_result = src_a << shamt;
            4'b1000: alu_result = src_a >> shamt;
            4'b1001: alu_result = $unsigned($signed(src_a) >>> shamt);
            4'b1010: alu_result = src_b;
            default: alu_result = '0;
        endcase
    end

    // Branch compare always uses the register operands, even when the ALU takes the immediate.
    always_comb begin
        cond = 1'b0;
        case (funct3E)
            3'b000:  cond = (src_a == fwd_b);
            3'b001:  cond = (src_a != fwd_b);
            3'b100:  cond = ($signed(src_a) <  $signed(fwd_b));
            3'b101:  cond = ($signed(src_a) >= $signed(fwd_b));
            3'b110:  cond = (src_a <  fwd_b);
            3'b111:  cond = (src_a >= fwd_b);
            default: cond = 1'b0;
        endcase
    end

    assign taken       = branchE & cond;
    assign pcsrcE      = jumpE | taken;
    assign target_base = jalrE ? src_a : pcE;
    assign target_sum  = target_base + immextE;
    // JALR targets are halfword-aligned by clearing bit 0.
    assign pctargetE   = target_sum & ~{{(XLEN-1){1'b0}}, jalrE};

    always_comb begin
        regwrite_d  = regwriteE;
        resultsrc_d = resultsrcE;
        memwrite_d  = memwriteE;
        // Jumps write the link address instead of the ALU result.
        aluresult_d = jumpE ? pcincr4E : alu_result;
        // Store data is the forwarded rs2, never the immediate.
        writedata_d = fwd_b;
        rd_d        = RDE;
        pcincr4_d   = pcincr4E;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            memwrite_q  <= 1'b0;
            aluresult_q <= '0;
            writedata_q <= '0;
            rd_q        <= '0;
            pcincr4_q   <= '0;
        end else begin
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            memwrite_q  <= memwrite_d;
            aluresult_q <= aluresult_d;
            writedata_q <= writedata_d;
            rd_q        <= rd_d;
            pcincr4_q   <= pcincr4_d;
        end
    end

    assign regwriteM  = regwrite_q;
    assign resultsrcM = resultsrc_q;
    assign memwriteM  = memwrite_q;
    assign aluresultM = aluresult_q;
    assign writedataM = writedata_q;
    assign RDM        = rd_q;
    assign pcincr4M   = pcincr4_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: reset, ALU ops, forwarding, store, branches, jumps.
// Latency: registered outputs are checked 1 time unit after the capturing clock edge.
// Backpressure: not applicable; inputs are driven away from the rising edge.
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        regwriteE, resultsrcE, memwriteE, jumpE, jalrE, branchE, alusrcE;
    logic [2:0]  funct3E;
    logic [3:0]  alucontrolE;
    logic [31:0] RD1E, RD2E, immextE, pcE, pcincr4E, resultW;
    logic [4:0]  RDE;
    logic [1:0]  forwardAE, forwardBE;
    logic        pcsrcE;
    logic [31:0] pctargetE;
    logic        regwriteM, resultsrcM, memwriteM;
    logic [31:0] aluresultM, writedataM, pcincr4M;
    logic [4:0]  RDM;

    int errors = 0;
    int checks = 0;

    execute_stage #(.XLEN(32), .RW(5)) dut (
        .clk(clk), .rst(rst),
        .regwriteE(regwriteE), .resultsrcE(resultsrcE), .memwriteE(memwriteE),
        .jumpE(jumpE), .jalrE(jalrE), .branchE(branchE), .funct3E(funct3E),
        .alucontrolE(alucontrolE), .alusrcE(alusrcE),
        .RD1E(RD1E), .RD2E(RD2E), .immextE(immextE), .pcE(pcE), .pcincr4E(pcincr4E),
        .RDE(RDE), .forwardAE(forwardAE), .forwardBE(forwardBE), .resultW(resultW),
        .pcsrcE(pcsrcE), .pctargetE(pctargetE),
        .regwriteM(regwriteM), .resultsrcM(resultsrcM), .memwriteM(memwriteM),
        .aluresultM(aluresultM), .writedataM(writedataM), .RDM(RDM), .pcincr4M(pcincr4M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        regwriteE = 0; resultsrcE = 0; memwriteE = 0; jumpE = 0; jalrE = 0;
        branchE = 0; alusrcE = 0; funct3E = 3'b000; alucontrolE = 4'b0000;
        RD1E = 0; RD2E = 0; immextE = 0; pcE = 0; pcincr4E = 0; resultW = 0;
        RDE = 0; forwardAE = 2'b00; forwardBE = 2'b00;
    endtask

    task automatic check_all_m_zero(input string tag);
        check({tag, "_regwriteM"},  {31'b0, regwriteM},  32'h0);
        check({tag, "_resultsrcM"}, {31'b0, resultsrcM}, 32'h0);
        check({tag, "_memwriteM"},  {31'b0, memwriteM},  32'h0);
        check({tag, "_aluresultM"}, aluresultM,          32'h0);
        check({tag, "_writedataM"}, writedataM,          32'h0);
        check({tag, "_RDM"},        {27'b0, RDM},        32'h0);
        check({tag, "_pcincr4M"},   pcincr4M,            32'h0);
    endtask

    logic [3:0]  sweep_op  [12];
    logic [31:0] sweep_exp [12];

    initial begin
        rst = 1'b0;
        clear_inputs();
        #1 rst = 1'b1;
        #1;
        check_all_m_zero("reset_initial");
        @(negedge clk);
        rst = 1'b0;

        // First capture after reset release: 5 + 7.
        RD1E = 32'd5; RD2E = 32'd7; regwriteE = 1; RDE = 5'd3; pcincr4E = 32'h14;
        tick();
        check("first_add_result", aluresultM, 32'd12);
        check("first_add_regwrite", {31'b0, regwriteM}, 32'h1);
        check("first_add_rd", {27'b0, RDM}, 32'd3);
        check("first_add_pc4", pcincr4M, 32'h14);
        check("first_add_wdata", writedataM, 32'd7);

        // ALU sweep with srcA = 0xFFFFFFF0, srcB = 4.
        sweep_op[0]  = 4'b0000; sweep_exp[0]  = 32'hFFFFFFF4; // add
        sweep_op[1]  = 4'b0001; sweep_exp[1]  = 32'hFFFFFFEC; // sub
        sweep_op[2]  = 4'b0010; sweep_exp[2]  = 32'h00000000; // and
        sweep_op[3]  = 4'b0011; sweep_exp[3]  = 32'hFFFFFFF4; // or
        sweep_op[4]  = 4'b0100; sweep_exp[4]  = 32'hFFFFFFF4; // xor
        sweep_op[5]  = 4'b0101; sweep_exp[5]  = 32'h00000001; // slt
        sweep_op[6]  = 4'b0110; sweep_exp[6]  = 32'h00000000; // sltu
        sweep_op[7]  = 4'b0111; sweep_exp[7]  = 32'hFFFFFF00; // sll
        sweep_op[8]  = 4'b1000; sweep_exp[8]  = 32'h0FFFFFFF; // srl
        sweep_op[9]  = 4'b1001; sweep_exp[9]  = 32'hFFFFFFFF; // sra
        sweep_op[10] = 4'b1010; sweep_exp[10] = 32'h00000004; // pass srcB
        sweep_op[11] = 4'b1011; sweep_exp[11] = 32'h00000000; // reserved
        RD1E = 32'hFFFFFFF0; RD2E = 32'd4;
        for (int i = 0; i < 12; i++) begin
            alucontrolE = sweep_op[i];
            tick();
            check($sformatf("alu_op_%0d", i), aluresultM, sweep_exp[i]);
        end

        // Back-to-back dependency through the EX->EX bypass.
        alucontrolE = 4'b0000; RD1E = 32'd3; RD2E = 32'd4; RDE = 5'd1;
        tick();
        check("fwd_producer", aluresultM, 32'd7);
        RD1E = 32'd99; RD2E = 32'd1; forwardAE = 2'b10; RDE = 5'd2;
        tick();
        check("fwd_a_mem", aluresultM, 32'd8);
        RD1E = 32'd1; RD2E = 32'd55; forwardAE = 2'b00; forwardBE = 2'b01; resultW = 32'd100;
        tick();
        check("fwd_b_wb", aluresultM, 32'd101);
        check("fwd_b_wdata", writedataM, 32'd100);

        // Store: address from immediate, data from forwarded rs2.
        regwriteE = 0; memwriteE = 1; alusrcE = 1; immextE = 32'd8; RD1E = 32'h100;
        RD2E = 32'h55; forwardBE = 2'b01; resultW = 32'hAB;
        tick();
        check("store_addr", aluresultM, 32'h108);
        check("store_wdata", writedataM, 32'hAB);
        check("store_memwrite", {31'b0, memwriteM}, 32'h1);
        check("store_regwrite", {31'b0, regwriteM}, 32'h0);

        // Branches (combinational); alusrcE=1 must not affect the compare.
        clear_inputs();
        branchE = 1; funct3E = 3'b001; RD1E = 32'd1; RD2E = 32'd2; alusrcE = 1;
        pcE = 32'h40; immextE = 32'hFFFFFFF8;
        #1;
        check("bne_taken", {31'b0, pcsrcE}, 32'h1);
        check("bne_target", pctargetE, 32'h38);
        funct3E = 3'b000; #1;
        check("beq_not_taken", {31'b0, pcsrcE}, 32'h0);
        RD1E = 32'hFFFFFFFF; funct3E = 3'b100; #1;
        check("blt_signed_taken", {31'b0, pcsrcE}, 32'h1);
        funct3E = 3'b110; #1;
        check("bltu_not_taken", {31'b0, pcsrcE}, 32'h0);
        funct3E = 3'b010; #1;
        check("undef_funct3", {31'b0, pcsrcE}, 32'h0);
        funct3E = 3'b001; branchE = 0; #1;
        check("no_branch_flag", {31'b0, pcsrcE}, 32'h0);

        // JALR: bit 0 of the target cleared, link value registered.
        clear_inputs();
        jumpE = 1; jalrE = 1; alusrcE = 1; RD1E = 32'h203; immextE = 32'h0;
        pcE = 32'h44; pcincr4E = 32'h48; regwriteE = 1; RDE = 5'd1;
        #1;
        check("jalr_pcsrc", {31'b0, pcsrcE}, 32'h1);
        check("jalr_target", pctargetE, 32'h202);
        tick();
        check("jalr_link", aluresultM, 32'h48);
        // JAL: PC-relative, bit 0 untouched.
        jalrE = 0; pcE = 32'h40; immextE = 32'h11; #1;
        check("jal_target", pctargetE, 32'h51);

        // Reset asserted mid-cycle with live nonzero state.
        clear_inputs();
        regwriteE = 1; resultsrcE = 1; memwriteE = 1; RD1E = 32'h10; RD2E = 32'h20;
        RDE = 5'd9; pcincr4E = 32'h80;
        tick();
        check("pre_reset_live", aluresultM, 32'h30);
        jumpE = 1;
        #2 rst = 1'b1;
        #1;
        check_all_m_zero("reset_midrun");
        check("reset_pcsrc_follows", {31'b0, pcsrcE}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        // Bypass from the just-reset register must read 0.
        clear_inputs();
        forwardAE = 2'b10; RD1E = 32'h77; RD2E = 32'd5;
        tick();
        check("fwd_after_reset", aluresultM, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (E) stage of the 5-stage RV32I pipeline.
- Takes E-stage operands and controls from the decode/execute register, applies forwarding, and runs the ALU.
- Resolves branches and jumps combinationally toward fetch.
- Registers results into the E->M pipeline register that directly feeds the Memory stage (regwriteM, resultsrcM, memwriteM, aluresultM, writedataM, RDM, pcincr4M).

Parameters:
- XLEN, 32, datapath width
- RW, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- regwriteE  in  1  register-file write enable
- resultsrcE  in  1  0=ALU result, 1=memory read data
- memwriteE  in  1  data-memory write enable
- jumpE  in  1  JAL/JALR
- jalrE  in  1  JALR (target base is srcA)
- branchE  in  1  conditional branch
- funct3E  in  3  branch condition (000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu)
- alucontrolE  in  4  ALU op
- alusrcE  in  1  0=srcB from forwarded RD2, 1=immextE
- RD1E  in  XLEN  rs1 register-file data
- RD2E  in  XLEN  rs2 register-file data
- immextE  in  XLEN  sign-extended immediate
- pcE  in  XLEN  instruction PC
- pcincr4E  in  XLEN  PC+4
- RDE  in  RW  destination register
- forwardAE  in  2  srcA select
- forwardBE  in  2  srcB select
- resultW  in  XLEN  writeback result, for forwarding
- pcsrcE  out  1  redirect fetch (combinational)
- pctargetE  out  XLEN  redirect target (combinational)
- regwriteM  out  1  registered
- resultsrcM  out  1  registered
- memwriteM  out  1  registered
- aluresultM  out  XLEN  registered
- writedataM  out  XLEN  registered
- RDM  out  RW  registered
- pcincr4M  out  XLEN  registered

Behaviour:
- Forwarding, srcA (selected by forwardAE):
  - 00: RD1E
  - 01: resultW
  - 10: aluresultM (this block's own registered output)
  - 11: RD1E
- Forwarding, fwdB (selected by forwardBE): same encoding, with RD2E in place of RD1E.
- srcB = alusrcE ? immextE : fwdB.
- ALU ops (alucontrolE), all XLEN-bit with wrap-around and no overflow flag:
  - 0000 add; 0001 sub; 0010 and; 0011 or; 0100 xor
  - 0101 slt (signed, result 0/1); 0110 sltu; 0111 sll; 1000 srl; 1001 sra
  - 1010 pass srcB (LUI)
  - 1011–1111: result 0
  - Shift amount = srcB[4:0].
- Branch compare uses srcA vs fwdB, independent of alusrcE.
  - taken = branchE & cond(funct3E).
  - Undefined funct3 (010, 011) → not taken.
- pcsrcE = jumpE | taken.
- pctargetE = (jalrE ? srcA : pcE) + immextE; when jalrE, bit 0 is cleared.
- E->M register, updated every rising clk edge (no stall, no flush; bubbles arrive as zeroed controls):
  - aluresultM <= jumpE ? pcincr4E : ALU result (link value for JAL/JALR).
  - writedataM <= fwdB (forwarded store data, never immextE).
  - regwriteM, resultsrcM, memwriteM, RDM, pcincr4M <= E-stage copies.
- Latency: one cycle E->M for registered outputs; pcsrcE and pctargetE are same-cycle.
- Reset: while rst=1 (asynchronous assert), every registered output = 0.
  - Reset deasserts synchronously to the design; the first capture happens on the first rising edge with rst=0.
  - Reset mid-instruction discards that instruction; no partial state remains.
  - During reset, pcsrcE/pctargetE still follow their inputs; fetch ignores them.
- Forward select 10 during the cycle right after reset yields 0.
- A store with regwriteE=0 still latches aluresultM (the address).

Test Plan:
- Reset: rst=1 mid-run with nonzero inputs → all M outputs 0 immediately; after release and one edge, add 5+7 → aluresultM=12.
- ALU sweep: srcA=0xFFFFFFF0, srcB=4 → add 0xFFFFFFF4, slt 1, sltu 0, sra 0xFFFFFFFF, srl 0x0FFFFFFF, sub 0xFFFFFFEC.
- Forwarding: back-to-back add x1=3+4 then add x2=x1+1 with forwardAE=10 → second aluresultM=8; repeat with forwardBE=01, resultW=100 → 101.
- Store: memwriteE=1, alusrcE=1, immextE=8, RD1E=0x100, forwardBE=01, resultW=0xAB → aluresultM=0x108, writedataM=0xAB, memwriteM=1.
- Branch: bne, srcA=1, fwdB=2, pcE=0x40, imm=-8 → pcsrcE=1, pctargetE=0x38; beq with same operands → pcsrcE=0.
- JALR: jalrE=jumpE=1, srcA=0x203, imm=0 → pctargetE=0x202, aluresultM=pcincr4E.
